// File: rtl/load_store_unit.sv
// Multi-cycle LOAD/STORE engine: one core request becomes one data-memory bus transaction.
// Optional bus-wait abort is enabled by defining LSU_TIMEOUT_EN.
module load_store_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [3:0]  opcode,
    input  logic [16:0] rs1_data,
    input  logic [16:0] rd_data,
    input  logic [3:0]  imm4,
    output logic        busy,
    output logic        done,
    output logic [16:0] result,
    output logic        result_we,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic        mem_ready,
    input  logic        mem_rvalid,
    input  logic [15:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT_R,
        DONE
    } state_t;

    localparam logic [3:0] OP_LOAD  = 4'hC;
    localparam logic [3:0] OP_STORE = 4'hD;

    state_t      state;
    state_t      state_nxt;
    logic [15:0] addr_q;
    logic [15:0] wdata_q;
    logic        we_q;
    logic [16:0] result_q;
    logic        accept;
    logic        timeout_hit;

    assign accept = start && ((opcode == OP_LOAD) || (opcode == OP_STORE));

    // Only the low 16 bits of the register operands carry address/data.
    logic unused_flags;
    assign unused_flags = &{1'b0, rs1_data[16], rd_data[16]};

`ifdef LSU_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] wait_cnt;

    // Counter holds the number of wait cycles already spent, so the limit
    // is reached during the TIMEOUT_CYCLES-th cycle of REQ or WAIT_R.
    assign timeout_hit = (wait_cnt == TIMEOUT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else begin
            case (state)
                IDLE:    if (accept) wait_cnt <= '0;
                REQ:     wait_cnt <= mem_ready ? '0 : wait_cnt + 16'd1;
                WAIT_R:  wait_cnt <= wait_cnt + 16'd1;
                default: wait_cnt <= wait_cnt;
            endcase
        end
    end
`else
    logic unused_cfg;
    assign unused_cfg  = &{1'b0, TIMEOUT_CYCLES[0]};
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) state_nxt = REQ;
            end
            REQ: begin
                if (mem_ready)        state_nxt = we_q ? DONE : WAIT_R;
                else if (timeout_hit) state_nxt = DONE;
            end
            WAIT_R: begin
                if (mem_rvalid)       state_nxt = DONE;
                else if (timeout_hit) state_nxt = DONE;
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q   <= '0;
            wdata_q  <= '0;
            we_q     <= 1'b0;
            result_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        addr_q  <= rs1_data[15:0] + {12'b0, imm4};
                        wdata_q <= rd_data[15:0];
                        we_q    <= (opcode == OP_STORE);
                    end
                end
                REQ: begin
                    // An aborted LOAD returns the bus-error flag with zero data.
                    if (!mem_ready && timeout_hit && !we_q) result_q <= 17'h10000;
                end
                WAIT_R: begin
                    if (mem_rvalid)       result_q <= {1'b0, mem_rdata};
                    else if (timeout_hit) result_q <= 17'h10000;
                end
                default: begin
                    result_q <= result_q;
                end
            endcase
        end
    end

    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign result_we = (state == DONE) && !we_q;
    assign mem_req   = (state == REQ);
    assign mem_we    = (state == REQ) && we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign result    = result_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: vector table of single transactions plus
// hand-written sequences for ignored requests, reset, and the optional timeout.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [3:0]  opcode;
    logic [16:0] rs1_data;
    logic [16:0] rd_data;
    logic [3:0]  imm4;
    logic        busy;
    logic        done;
    logic [16:0] result;
    logic        result_we;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_ready;
    logic        mem_rvalid;
    logic [15:0] mem_rdata;

    always #5 clk = ~clk;

    load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .opcode     (opcode),
        .rs1_data   (rs1_data),
        .rd_data    (rd_data),
        .imm4       (imm4),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .result_we  (result_we),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ready  (mem_ready),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    int checks   = 0;
    int failures = 0;
    int done_cnt = 0;
    int acc_cnt  = 0;

    always @(posedge clk) begin
        if (done) done_cnt++;
        if (mem_req && mem_ready) acc_cnt++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [3:0]  op;
        logic [16:0] rs1;
        logic [16:0] rd;
        logic [3:0]  imm;
        int unsigned rdy_wait;
        int unsigned rv_wait;
        logic [15:0] rdata;
        logic [15:0] exp_addr;
        logic [15:0] exp_wdata;
        logic [16:0] exp_result;
    } vec_t;

    vec_t vecs[5];

    task automatic run_vec(input vec_t v);
        logic is_store;
        is_store = (v.op == 4'hD);
        @(negedge clk);
        check("idle_before_start", busy, 1'b0);
        start = 1'b1; opcode = v.op; rs1_data = v.rs1; rd_data = v.rd; imm4 = v.imm;
        @(negedge clk);
        start = 1'b0; opcode = 4'h0; rs1_data = '0; rd_data = '0; imm4 = '0;
        check("req_n1", mem_req, 1'b1);
        check("busy_n1", busy, 1'b1);
        check("addr_n1", mem_addr, v.exp_addr);
        check("we_n1", mem_we, is_store);
        if (is_store) check("wdata_n1", mem_wdata, v.exp_wdata);
        for (int i = 0; i < int'(v.rdy_wait); i++) begin
            @(negedge clk);
            check("stall_req", mem_req, 1'b1);
            check("stall_addr", mem_addr, v.exp_addr);
        end
        mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
        check("req_drop", mem_req, 1'b0);
        if (!is_store) begin
            for (int i = 1; i < int'(v.rv_wait); i++) begin
                check("wait_no_done", done, 1'b0);
                @(negedge clk);
            end
            check("wait_no_done", done, 1'b0);
            mem_rvalid = 1'b1; mem_rdata = v.rdata;
            @(negedge clk);
            mem_rvalid = 1'b0; mem_rdata = 16'hDEAD;
        end
        check("done_pulse", done, 1'b1);
        check("result_we", result_we, !is_store);
        check("result", result, v.exp_result);
        @(negedge clk);
        check("done_clear", done, 1'b0);
        check("busy_clear", busy, 1'b0);
        check("result_hold", result, v.exp_result);
    endtask

    initial begin
        int base_done;
        int base_acc;

        rst_n = 1'b0; start = 1'b0; opcode = '0; rs1_data = '0; rd_data = '0; imm4 = '0;
        mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;

        vecs[0] = '{4'hD, 17'h01000, 17'h0ABCD, 4'h3, 0, 0, 16'h0000, 16'h1003, 16'hABCD, 17'h00000};
        vecs[1] = '{4'hC, 17'h02000, 17'h00000, 4'h0, 2, 3, 16'h5A5A, 16'h2000, 16'h0000, 17'h05A5A};
        vecs[2] = '{4'hC, 17'h1FFFE, 17'h00000, 4'h5, 0, 1, 16'h1234, 16'h0003, 16'h0000, 17'h01234};
        vecs[3] = '{4'hD, 17'h0FFFF, 17'h18001, 4'hF, 1, 0, 16'h0000, 16'h000E, 16'h8001, 17'h01234};
        vecs[4] = '{4'hC, 17'h00000, 17'h00000, 4'h0, 0, 2, 16'hFFFF, 16'h0000, 16'h0000, 17'h0FFFF};

        repeat (3) @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_result_we", result_we, 1'b0);
        check("rst_mem_req", mem_req, 1'b0);
        check("rst_mem_we", mem_we, 1'b0);
        check("rst_mem_addr", mem_addr, 16'h0);
        check("rst_mem_wdata", mem_wdata, 16'h0);
        check("rst_result", result, 17'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) run_vec(vecs[i]);
        check("table_done_count", done_cnt, 5);
        check("table_accept_count", acc_cnt, 5);

        // Unsupported opcode, stray ready/rvalid, starts while busy.
        base_done = done_cnt; base_acc = acc_cnt;
        @(negedge clk);
        start = 1'b1; opcode = 4'h4; rs1_data = 17'h03000; mem_ready = 1'b1; mem_rvalid = 1'b1;
        @(negedge clk);
        start = 1'b0; mem_ready = 1'b0; mem_rvalid = 1'b0;
        check("badop_busy", busy, 1'b0);
        check("badop_req", mem_req, 1'b0);
        @(negedge clk);
        check("badop_done", done, 1'b0);
        start = 1'b1; opcode = 4'hC; rs1_data = 17'h00040; imm4 = 4'h2;
        @(negedge clk);
        opcode = 4'hD; rs1_data = 17'h07777; imm4 = 4'h0;
        mem_rvalid = 1'b1; mem_rdata = 16'hBAD1;
        check("ign_addr", mem_addr, 16'h0042);
        check("ign_we", mem_we, 1'b0);
        @(negedge clk);
        opcode = 4'hC;
        check("ign_rvalid_in_req", mem_req, 1'b1);
        check("ign_addr_stable", mem_addr, 16'h0042);
        mem_ready = 1'b1; mem_rvalid = 1'b1; mem_rdata = 16'hDEAD;
        @(negedge clk);
        mem_ready = 1'b0; mem_rvalid = 1'b0;
        check("same_cycle_rvalid_ignored", done, 1'b0);
        check("wait_busy", busy, 1'b1);
        mem_rvalid = 1'b1; mem_rdata = 16'h4321;
        @(negedge clk);
        mem_rvalid = 1'b0;
        check("ign_done", done, 1'b1);
        check("ign_result_we", result_we, 1'b1);
        check("ign_result", result, 17'h04321);
        start = 1'b0;
        @(negedge clk);
        check("no_accept_from_done", busy, 1'b0);
        @(negedge clk);
        check("ign_done_count", done_cnt - base_done, 1);
        check("ign_accept_count", acc_cnt - base_acc, 1);

        // Reset while waiting for read data, then a stale response.
        base_done = done_cnt;
        start = 1'b1; opcode = 4'hC; rs1_data = 17'h00100; imm4 = 4'h0;
        @(negedge clk);
        start = 1'b0;
        check("rst_seq_req", mem_req, 1'b1);
        mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
        check("rst_seq_wait_busy", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check("async_rst_req", mem_req, 1'b0);
        check("async_rst_busy", busy, 1'b0);
        check("async_rst_done", done, 1'b0);
        check("async_rst_result", result, 17'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        mem_rvalid = 1'b1; mem_rdata = 16'h9999;
        @(negedge clk);
        mem_rvalid = 1'b0;
        check("late_rvalid_done", done, 1'b0);
        check("late_rvalid_result", result, 17'h0);
        @(negedge clk);
        check("late_rvalid_done_count", done_cnt - base_done, 0);

        // Reset while the request is on the bus.
        base_acc = acc_cnt;
        start = 1'b1; opcode = 4'hD; rs1_data = 17'h00200; rd_data = 17'h00055;
        @(negedge clk);
        start = 1'b0;
        check("rst_req_before", mem_req, 1'b1);
        rst_n = 1'b0;
        #1;
        check("rst_req_after", mem_req, 1'b0);
        check("rst_req_we", mem_we, 1'b0);
        @(negedge clk);
        rst_n = 1'b1; mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
        check("rst_req_idle", busy, 1'b0);
        check("rst_req_no_accept", acc_cnt - base_acc, 0);

`ifdef LSU_TIMEOUT_EN
        // LOAD with ready never given: four REQ cycles, then error result.
        @(negedge clk);
        start = 1'b1; opcode = 4'hC; rs1_data = 17'h00500; imm4 = 4'h0;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("to_load_req", mem_req, 1'b1);
            check("to_load_no_done", done, 1'b0);
            @(negedge clk);
        end
        check("to_load_req_drop", mem_req, 1'b0);
        check("to_load_done", done, 1'b1);
        check("to_load_result_we", result_we, 1'b1);
        check("to_load_result", result, 17'h10000);
        @(negedge clk);
        check("to_load_idle", busy, 1'b0);

        // STORE timeout: done only, result untouched.
        start = 1'b1; opcode = 4'hD; rs1_data = 17'h00600; rd_data = 17'h01111;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("to_store_done", done, 1'b1);
        check("to_store_result_we", result_we, 1'b0);
        check("to_store_result", result, 17'h10000);
        @(negedge clk);

        // Handshakes landing exactly on the limit cycle win in REQ and WAIT_R.
        start = 1'b1; opcode = 4'hC; rs1_data = 17'h00700;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("limit_req_still", mem_req, 1'b1);
        mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
        check("limit_ready_wins", done, 1'b0);
        check("limit_wait_busy", busy, 1'b1);
        repeat (3) begin
            @(negedge clk);
            check("limit_wait_no_done", done, 1'b0);
        end
        mem_rvalid = 1'b1; mem_rdata = 16'h0777;
        @(negedge clk);
        mem_rvalid = 1'b0;
        check("limit_rvalid_done", done, 1'b1);
        check("limit_rvalid_result", result, 17'h00777);
        @(negedge clk);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Multi-cycle LOAD/STORE engine for the 16-bit core. It executes opcodes 4'hC (LOAD) and 4'hD (STORE), which the combinational ALU does not handle. It converts one core-side request into a single data-memory bus transaction with a valid/ready handshake and returns a 17-bit register value (16-bit data + flag) for LOAD. It sits between decode/register-file and the data-memory port.

Parameters:
TIMEOUT_CYCLES, 255, bus wait-cycle limit before abort (used only with LSU_TIMEOUT_EN; range 1..65535)

Ports:
clk  input  1  core clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request strobe from core, sampled only in IDLE
opcode  input  4  4'hC = LOAD, 4'hD = STORE; any other value makes start ignored
rs1_data  input  17  address base; only bits [15:0] used
rd_data  input  17  store data; only bits [15:0] used
imm4  input  4  unsigned address offset
busy  output  1  high while state != IDLE
done  output  1  one-cycle pulse when an operation completes
result  output  17  LOAD return value {flag, data}
result_we  output  1  one-cycle pulse with done, for LOAD only
mem_req  output  1  bus request valid
mem_we  output  1  1 = write, 0 = read; valid while mem_req
mem_addr  output  16  word address; valid while mem_req
mem_wdata  output  16  write data; valid while mem_req && mem_we
mem_ready  input  1  bus accepts request when mem_req && mem_ready
mem_rvalid  input  1  read data valid
mem_rdata  input  16  read data

Behaviour:
- Reset values: state=IDLE; busy, done, result_we, mem_req, mem_we = 0; mem_addr, mem_wdata = 0; result = 17'h0. Reset is asynchronous, so mem_req drops in the same cycle rst_n falls, including mid-transaction. Responses arriving after reset are ignored.
- FSM states:
  - IDLE: start && (opcode==C || opcode==D) is accepted. On acceptance, register addr = rs1_data[15:0] + {12'b0, imm4}. The sum is mod 2^16, so it wraps with no carry out. Also register wdata = rd_data[15:0] and we = (opcode==D). Next state is REQ.
  - REQ: mem_req=1 with addr/we/wdata held stable until accepted (mem_ready=1). On accept: STORE goes to DONE; LOAD goes to WAIT_R.
  - WAIT_R: wait for mem_rvalid. mem_rvalid in the same cycle as the REQ accept is not observed; the earliest data is one cycle after accept. On mem_rvalid, result <= {1'b0, mem_rdata} and next state is DONE.
  - DONE: done=1 for one cycle, and result_we=1 if the operation was a LOAD. Next state is IDLE.
- Latency from start sampled at cycle N:
  - mem_req high at N+1.
  - Zero-wait STORE (ready at N+1): done at N+2.
  - Zero-wait LOAD (ready at N+1, rvalid at N+2): done at N+3.
  - Each wait cycle adds one.
- done/result_we are registered outputs, decoded from state.
- result holds its value until the next LOAD completes; STORE never changes result.
- start while busy is ignored, with no queuing.
- start with an unsupported opcode is ignored: no bus activity, no done.
- mem_rvalid outside WAIT_R is ignored.
- mem_ready while mem_req=0 is ignored.
- Back-to-back: start may be accepted in the cycle after DONE (IDLE). There is no same-cycle DONE→accept.

Optional Feature:
LSU_TIMEOUT_EN
- Defined:
  - A 16-bit wait counter clears on entry to REQ and on REQ→WAIT_R, and increments each cycle in REQ or WAIT_R.
  - When it reaches TIMEOUT_CYCLES without the awaited handshake, the FSM goes to DONE and mem_req drops.
  - For LOAD: result <= {1'b1, 16'h0000}, i.e. flag set marks a bus error, with result_we=1.
  - For STORE: done only.
  - If the handshake occurs in the same cycle the limit is reached, the handshake wins.
- Undefined: no counter; the FSM waits indefinitely.

Test Plan:
- STORE, zero-wait: start with opcode D, rs1=0x1000, imm4=3, rd=0x0ABCD. Required: mem_req at N+1 with addr 0x1003, we=1, wdata 0xABCD; done at N+2; result_we=0; result unchanged.
- LOAD with waits: opcode C, rs1=0x2000, imm4=0, ready after 2 stall cycles, rvalid 3 cycles after accept with rdata 0x5A5A. Required: addr held stable during the stall; done and result_we on the cycle after rvalid; result=17'h05A5A.
- Address wrap: rs1=0x1FFFE (flag set), imm4=5. Required: mem_addr=0x0003.
- Ignored starts: start pulses during an active LOAD, plus start with opcode 4 while idle. Required: exactly one bus transaction and one done.
- Reset mid-operation: assert rst_n=0 in WAIT_R. Required: mem_req, busy and done are 0 immediately and result=0; a late rvalid after release causes no done.
- LSU_TIMEOUT_EN with TIMEOUT_CYCLES=4: LOAD with mem_ready held 0. Required: mem_req drops after 4 REQ cycles; done and result_we pulse; result=17'h10000.
